// File: rtl/fifo_ptr_pkg.sv
// Shared async-FIFO pointer helpers: Gray/binary conversion and width helpers.
// Functions work on a wide vector; callers zero-extend and truncate to width.
package fifo_ptr_pkg;

    localparam int PMAX = 32;

    function automatic int ptrw(input int addrsize);
        return addrsize + 1;
    endfunction

    function automatic int depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    // Leading zeros of a narrower pointer leave the low bits unchanged.
    function automatic logic [PMAX-1:0] gray2bin(input logic [PMAX-1:0] g);
        logic [PMAX-1:0] b;
        b[PMAX-1] = g[PMAX-1];
        for (int i = PMAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PMAX-1:0] bin2gray(input logic [PMAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_vec_chain.sv
// Generic N-flop vector synchronizer; only the first stage may go metastable.
// Used for both r2w and w2r pointer crossings.
module sync_vec_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                s[i] <= '0;
            end
        end else begin
            s[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                s[i] <= s[i-1];
            end
        end
    end

    assign q = s[STAGES-1];

endmodule

// File: rtl/ptr_sync_r2w_mon.sv
// Read->write Gray pointer synchronizer with write-side fill level,
// advance reporting, almost-full and a sticky illegal-jump monitor.
module ptr_sync_r2w_mon
    import fifo_ptr_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 2
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic [ADDRSIZE:0] rptr,
    input  logic [ADDRSIZE:0] wbin,
    input  logic              err_clr,
    output logic [ADDRSIZE:0] wq_rptr,
    output logic [ADDRSIZE:0] wq_rbin,
    output logic              w_rd_adv,
    output logic [ADDRSIZE:0] w_rd_delta,
    output logic [ADDRSIZE:0] wlevel,
    output logic              walmost_full,
    output logic              wptr_err
);

    localparam int PTRW  = ptrw(ADDRSIZE);
    localparam int DEPTH = depth(ADDRSIZE);

    localparam logic [PTRW-1:0] DEPTH_P = PTRW'(DEPTH);
    localparam logic [PTRW:0]   DEPTH_X = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   AF_X    = (PTRW+1)'(AF_MARGIN);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("SYNC_STAGES must be in 2..4");
    end

    if (AF_MARGIN < 0 || AF_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("AF_MARGIN must be in 0..DEPTH-1");
    end

    logic [PTRW-1:0] rbin_new;
    logic [PTRW-1:0] delta;
    logic [PTRW-1:0] lvl;
    logic            af;
    logic            err_set;

    sync_vec_chain #(
        .WIDTH (PTRW),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (wclk),
        .rst_n(wrst_n),
        .d    (rptr),
        .q    (wq_rptr)
    );

    always_comb begin
        rbin_new = PTRW'(gray2bin(PMAX'(wq_rptr)));
        delta    = rbin_new - wq_rbin;
        lvl      = wbin - rbin_new;
        // D - lvl <= margin, rearranged so it cannot underflow
        af       = ({1'b0, lvl} + AF_X) >= DEPTH_X;
        err_set  = (delta > DEPTH_P) || (lvl > DEPTH_P);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq_rbin      <= '0;
            w_rd_delta   <= '0;
            w_rd_adv     <= 1'b0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wq_rbin      <= rbin_new;
            w_rd_delta   <= delta;
            w_rd_adv     <= (delta != '0);
            wlevel       <= lvl;
            walmost_full <= af;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wptr_err <= 1'b0;
        end else if (err_set) begin
            wptr_err <= 1'b1;
        end else if (err_clr) begin
            wptr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ptr_sync_r2w_mon.sv
// Bench for ptr_sync_r2w_mon: 2- and 3-stage instances against a sample-history model.
// Directed scenarios first, then a random pointer walk with an async reset mid-stream.
module tb_ptr_sync_r2w_mon;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic [4:0] rptr;
    logic [4:0] wbin;
    logic       err_clr;

    logic [4:0] o_wq [2];
    logic [4:0] o_rb [2];
    logic       o_adv [2];
    logic [4:0] o_dl [2];
    logic [4:0] o_lv [2];
    logic       o_af [2];
    logic       o_err [2];

    logic [4:0] e_wq [2];
    logic [4:0] e_rb [2];
    logic       e_adv [2];
    logic [4:0] e_dl [2];
    logic [4:0] e_lv [2];
    logic       e_af [2];
    logic       e_err [2];

    logic [4:0] inv [32];
    logic [4:0] hist [$];
    int checks = 0;
    int fails  = 0;

    always #5 wclk = ~wclk;

    ptr_sync_r2w_mon #(.ADDRSIZE(4), .SYNC_STAGES(2), .AF_MARGIN(2)) u2 (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wbin(wbin),
        .err_clr(err_clr), .wq_rptr(o_wq[0]), .wq_rbin(o_rb[0]),
        .w_rd_adv(o_adv[0]), .w_rd_delta(o_dl[0]), .wlevel(o_lv[0]),
        .walmost_full(o_af[0]), .wptr_err(o_err[0])
    );

    ptr_sync_r2w_mon #(.ADDRSIZE(4), .SYNC_STAGES(3), .AF_MARGIN(2)) u3 (
        .wclk(wclk), .wrst_n(wrst_n), .rptr(rptr), .wbin(wbin),
        .err_clr(err_clr), .wq_rptr(o_wq[1]), .wq_rbin(o_rb[1]),
        .w_rd_adv(o_adv[1]), .w_rd_delta(o_dl[1]), .wlevel(o_lv[1]),
        .walmost_full(o_af[1]), .wptr_err(o_err[1])
    );

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = 5'(v);
        return b ^ (b >> 1);
    endfunction

    // Gray sample taken k edges before the most recent one (0 before reset history)
    function automatic logic [4:0] g_at(input int k);
        int idx;
        idx = hist.size() - 1 - k;
        return (idx >= 0) ? hist[idx] : 5'd0;
    endfunction

    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            hist.delete();
            for (int m = 0; m < 2; m++) begin
                e_wq[m] = 0; e_rb[m] = 0; e_adv[m] = 0; e_dl[m] = 0;
                e_lv[m] = 0; e_af[m] = 0; e_err[m] = 0;
            end
        end else begin
            hist.push_back(rptr);
            if (hist.size() > 8) void'(hist.pop_front());
            for (int m = 0; m < 2; m++) begin
                int s;
                int free;
                logic [4:0] rb, pv, dl, lv;
                s = m + 2;
                rb = inv[g_at(s)];
                pv = inv[g_at(s + 1)];
                dl = rb - pv;
                lv = wbin - rb;
                free = 16 - int'(lv);
                e_wq[m] = g_at(s - 1);
                e_rb[m] = rb;
                e_dl[m] = dl;
                e_adv[m] = (dl != 0);
                e_lv[m] = lv;
                e_af[m] = (free <= 2);
                if (dl > 16 || lv > 16) e_err[m] = 1'b1;
                else if (err_clr) e_err[m] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("wq_rptr[%0d]", m), 32'(o_wq[m]), 32'(e_wq[m]));
            chk($sformatf("wq_rbin[%0d]", m), 32'(o_rb[m]), 32'(e_rb[m]));
            chk($sformatf("adv[%0d]", m), 32'(o_adv[m]), 32'(e_adv[m]));
            chk($sformatf("delta[%0d]", m), 32'(o_dl[m]), 32'(e_dl[m]));
            chk($sformatf("wlevel[%0d]", m), 32'(o_lv[m]), 32'(e_lv[m]));
            chk($sformatf("af[%0d]", m), 32'(o_af[m]), 32'(e_af[m]));
            chk($sformatf("err[%0d]", m), 32'(o_err[m]), 32'(e_err[m]));
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_wq"}, 32'(o_wq[m]), 0);
            chk({tag, "_rb"}, 32'(o_rb[m]), 0);
            chk({tag, "_adv"}, 32'(o_adv[m]), 0);
            chk({tag, "_dl"}, 32'(o_dl[m]), 0);
            chk({tag, "_lv"}, 32'(o_lv[m]), 0);
            chk({tag, "_af"}, 32'(o_af[m]), 0);
            chk({tag, "_err"}, 32'(o_err[m]), 0);
        end
    endtask

    task automatic tick();
        @(negedge wclk);
        check_all();
    endtask

    task automatic do_reset(input int rb, input int wb);
        wrst_n = 1'b0;
        rptr = gray(rb);
        wbin = 5'(wb);
        err_clr = 1'b0;
        repeat (2) tick();
        chk_zero("rst");
        wrst_n = 1'b1;
    endtask

    task automatic settle_clear();
        repeat (5) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    initial begin
        int rp;
        for (int v = 0; v < 32; v++) inv[gray(v)] = 5'(v);

        // Reset with a far read pointer, then watch it arrive
        wrst_n = 1'b0;
        rptr = 5'b10110;
        wbin = 5'd0;
        err_clr = 1'b0;
        repeat (3) @(negedge wclk);
        chk_zero("t1_rst");
        wrst_n = 1'b1;
        tick();
        tick();
        chk("t1_wq", 32'(o_wq[0]), 32'b10110);
        tick();
        chk("t1_rbin", 32'(o_rb[0]), 27);
        chk("t1_delta", 32'(o_dl[0]), 27);
        chk("t1_adv", 32'(o_adv[0]), 1);
        chk("t1_err", 32'(o_err[0]), 1);

        // Latency on the 3-stage instance
        rptr = 5'd0;
        settle_clear();
        rptr = gray(1);
        wbin = 5'd1;
        tick();
        chk("t2_wq_k", 32'(o_wq[1]), 0);
        tick();
        chk("t2_wq_k1", 32'(o_wq[1]), 0);
        tick();
        chk("t2_wq_k2", 32'(o_wq[1]), 1);
        chk("t2_adv_k2", 32'(o_adv[1]), 0);
        tick();
        chk("t2_rbin", 32'(o_rb[1]), 1);
        chk("t2_adv", 32'(o_adv[1]), 1);
        chk("t2_delta", 32'(o_dl[1]), 1);
        tick();
        chk("t2_adv_off", 32'(o_adv[1]), 0);

        // Wrap 30 -> 31 -> 0 -> 1
        do_reset(30, 30);
        settle_clear();
        foreach (hist[i]) chk("t3_hist", 32'(inv[hist[i]]), 30);
        for (int i = 0; i < 3; i++) begin
            int v;
            v = (31 + i) % 32;
            rptr = gray(v);
            wbin = 5'(v);
            repeat (3) tick();
            chk("t3_delta", 32'(o_dl[0]), 1);
            chk("t3_rbin", 32'(o_rb[0]), v);
            repeat (2) tick();
            chk("t3_err", 32'(o_err[0]), 0);
        end

        // Level and almost-full thresholds
        do_reset(0, 0);
        repeat (4) tick();
        wbin = 5'd13;
        repeat (2) tick();
        chk("t4_lv13", 32'(o_lv[0]), 13);
        chk("t4_af13", 32'(o_af[0]), 0);
        wbin = 5'd14;
        repeat (2) tick();
        chk("t4_lv14", 32'(o_lv[0]), 14);
        chk("t4_af14", 32'(o_af[0]), 1);
        wbin = 5'd16;
        repeat (2) tick();
        chk("t4_lv16", 32'(o_lv[0]), 16);
        chk("t4_af16", 32'(o_af[0]), 1);
        chk("t4_err16", 32'(o_err[0]), 0);
        wbin = 5'd17;
        repeat (2) tick();
        chk("t4_err17", 32'(o_err[0]), 1);

        // Bursts, illegal jumps, set-beats-clear
        do_reset(3, 3);
        repeat (4) tick();
        chk("t5_err0", 32'(o_err[0]), 0);
        rptr = gray(8);
        wbin = 5'd8;
        repeat (3) tick();
        chk("t5_delta5", 32'(o_dl[0]), 5);
        chk("t5_adv5", 32'(o_adv[0]), 1);
        chk("t5_noerr", 32'(o_err[0]), 0);
        rptr = gray(25);
        wbin = 5'd25;
        repeat (3) tick();
        chk("t5_delta17", 32'(o_dl[0]), 17);
        chk("t5_err17", 32'(o_err[0]), 1);
        rptr = gray(10);
        repeat (2) tick();
        err_clr = 1'b1;
        tick();
        chk("t5_setwins", 32'(o_err[0]), 1);
        err_clr = 1'b0;
        repeat (3) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_clr2", 32'(o_err[0]), 0);
        chk("t5_clr3", 32'(o_err[1]), 0);

        // Random walk with an asynchronous reset mid-stream
        rp = 10;
        for (int i = 0; i < 160; i++) begin
            tick();
            if ($urandom_range(0, 15) == 0) rp += int'($urandom_range(0, 20));
            else rp += int'($urandom_range(0, 2));
            rptr = gray(rp);
            wbin = 5'(rp + int'($urandom_range(0, 16)));
            err_clr = ($urandom_range(0, 7) == 0);
            if (i == 80) begin
                @(posedge wclk);
                #3;
                wrst_n = 1'b0;
                #1;
                chk_zero("t6_async");
                @(negedge wclk);
                wrst_n = 1'b1;
            end
        end
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
